// File: rtl/jesd_capture_pkg.sv
// jesd_capture_pkg: shared trigger modes, FSM states and channel slicing for the frame capture block
package jesd_capture_pkg;
  localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
  localparam logic [1:0] TRIG_EXTERNAL  = 2'd1;
  localparam logic [1:0] TRIG_LEVEL     = 2'd2;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;
  function automatic int chan_offset(input int chan, input int sample_width);
    return chan * sample_width;
  endfunction
endpackage

// File: rtl/jesd_frame_capture_if.sv
// jesd_frame_capture_if: flattened frame input stream and backpressured burst output stream
interface jesd_frame_capture_if #(
  parameter int DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/jesd_capture_fifo.sv
// jesd_capture_fifo: single-clock first-word-fall-through FIFO with registered count/full/empty
module jesd_capture_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr, w_rd;
  assign o_full    = r_count == CW'(DEPTH);
  assign o_empty   = r_count == '0;
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end
endmodule

// File: rtl/jesd_frame_capture.sv
// jesd_frame_capture: arm/trigger burst capture of flattened JESD frames into a FIFO-backed AXI-Stream burst
module jesd_frame_capture
  import jesd_capture_pkg::*;
#(
  parameter int NUM_CHANNELS = 16,
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_aresetn,
  jesd_frame_capture_if.slave             axis,
  input  logic [LEN_WIDTH-1:0]            cfg_capture_len,
  input  logic [1:0]                      cfg_trig_mode,
  input  logic [$clog2(NUM_CHANNELS)-1:0] cfg_trig_chan,
  input  logic [SAMPLE_WIDTH-1:0]         cfg_trig_level,
  input  logic                            arm,
  input  logic                            abort,
  input  logic                            trig_in,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow,
  output logic [LEN_WIDTH-1:0]            frames_written
);
  localparam int DATA_WIDTH = NUM_CHANNELS * SAMPLE_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t                            r_state, w_next;
  logic [LEN_WIDTH-1:0]              r_len, r_frames;
  logic [1:0]                        r_mode;
  logic [$clog2(NUM_CHANNELS)-1:0]   r_chan;
  logic signed [SAMPLE_WIDTH-1:0]    r_level, r_prev, w_sample;
  logic                              r_prev_vld, r_pend, r_overflow;
  logic                              w_wr, w_ovf, w_pop, w_full, w_empty, w_last, w_trig, w_cross;
  logic [CW-1:0]                     w_count;
  assign w_sample = axis.s_axis_tdata[chan_offset(int'(r_chan), SAMPLE_WIDTH) +: SAMPLE_WIDTH];
  assign w_cross  = r_prev_vld && r_prev < r_level && w_sample >= r_level;
  assign w_trig   = axis.s_axis_tvalid && (r_mode == TRIG_EXTERNAL ? (trig_in || r_pend) :
                                           r_mode == TRIG_LEVEL    ? w_cross : 1'b1);
  assign w_pop    = !w_empty && axis.m_axis_tready;
  assign w_last   = r_state == DRAIN && w_count == CW'(1);
  assign axis.m_axis_tvalid = !w_empty;
  assign axis.m_axis_tlast  = w_last;
  assign done           = w_pop && w_last;
  assign busy           = r_state != IDLE;
  assign overflow       = r_overflow;
  assign frames_written = r_frames;
  jesd_capture_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (s_axis_aclk),
    .rst_n     (s_axis_aresetn),
    .i_wr_en   (w_wr),
    .i_wr_data (axis.s_axis_tdata),
    .i_rd_en   (w_pop),
    .o_rd_data (axis.m_axis_tdata),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );
  always_comb begin
    w_next = r_state;
    w_wr   = 1'b0;
    w_ovf  = 1'b0;
    case (r_state)
      IDLE: if (arm && !abort && cfg_capture_len != '0) w_next = ARMED;
      ARMED:
        if (abort) w_next = IDLE;
        else if (w_trig) begin
          w_wr   = 1'b1;
          w_next = r_len == LEN_WIDTH'(1) ? DRAIN : CAPTURE;
        end
      CAPTURE:
        // an abort that empties the FIFO this cycle must not strand DRAIN without a tlast beat
        if (abort) w_next = (w_count == '0 || (w_count == CW'(1) && w_pop)) ? IDLE : DRAIN;
        else if (axis.s_axis_tvalid && w_full) begin
          w_ovf  = 1'b1;
          w_next = DRAIN;
        end else if (axis.s_axis_tvalid) begin
          w_wr   = 1'b1;
          w_next = r_frames + LEN_WIDTH'(1) == r_len ? DRAIN : CAPTURE;
        end
      DRAIN: if (done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_mode     <= TRIG_IMMEDIATE;
      r_chan     <= '0;
      r_level    <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_pend     <= 1'b0;
      r_overflow <= 1'b0;
      r_frames   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == ARMED) begin
        r_len      <= cfg_capture_len;
        r_mode     <= cfg_trig_mode;
        r_chan     <= cfg_trig_chan;
        r_level    <= cfg_trig_level;
        r_prev_vld <= 1'b0;
        r_pend     <= 1'b0;
        r_overflow <= 1'b0;
        r_frames   <= '0;
      end
      if (r_state == ARMED) begin
        if (trig_in) r_pend <= 1'b1;
        if (axis.s_axis_tvalid) begin
          r_prev     <= w_sample;
          r_prev_vld <= 1'b1;
        end
      end
      if (w_ovf) r_overflow <= 1'b1;
      if (w_wr && !(&r_frames)) r_frames <= r_frames + LEN_WIDTH'(1);
    end
  end
endmodule

// File: doc/jesd_frame_capture.md
Name: jesd_frame_capture

Overview:
- Sits directly downstream of the JESD stream flattener wrapper; consumes its wide flattened frame stream (tvalid only, no backpressure).
- Captures a programmable-length burst of frames after an arm plus trigger event: immediate, external pulse, or rising level crossing on a selected channel.
- Buffers the burst in a small FIFO and emits it as a backpressured AXI-Stream burst with tlast toward the DMA/packetiser.
- Single clock domain (the flattener's output clock).

Parameters:
- NUM_CHANNELS, 16, samples per frame.
- SAMPLE_WIDTH, 16, bits per sample (signed, two's complement).
- DATA_WIDTH, NUM_CHANNELS*SAMPLE_WIDTH (256), frame width.
- FIFO_DEPTH, 16, burst FIFO entries; power of two, minimum 2.
- LEN_WIDTH, 16, width of capture length and frame counters.

Ports:
- s_axis_aclk  in  1  sole clock; all ports are synchronous to it.
- s_axis_aresetn  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  DATA_WIDTH  flattened frame; channel k at bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- s_axis_tvalid  in  1  frame valid; no tready, so a frame is lost if not taken.
- m_axis_tdata  out  DATA_WIDTH  captured frame.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of the burst.
- cfg_capture_len  in  LEN_WIDTH  frames per burst; sampled at arm.
- cfg_trig_mode  in  2  0 immediate, 1 external, 2 level, 3 reserved (treated as 0); sampled at arm.
- cfg_trig_chan  in  $clog2(NUM_CHANNELS)  level-trigger channel; sampled at arm.
- cfg_trig_level  in  SAMPLE_WIDTH  signed threshold; sampled at arm.
- arm  in  1  single-cycle arm pulse.
- abort  in  1  single-cycle abort pulse.
- trig_in  in  1  external trigger pulse.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the final beat is accepted.
- overflow  out  1  sticky; frame dropped because the FIFO was full.
- frames_written  out  LEN_WIDTH  frames written to the FIFO in the current or last burst.

Behaviour:
- Reset (s_axis_aresetn=0 at a clock edge):
  - state IDLE, FIFO emptied.
  - All outputs 0: m_axis_tvalid, m_axis_tlast, busy, done, overflow, frames_written.
  - A reset mid-burst discards everything, with no tlast and no done.
- State IDLE:
  - arm=1 with cfg_capture_len!=0 latches the config, clears overflow and frames_written, and moves to ARMED.
  - arm with len 0 is ignored.
  - arm outside IDLE is ignored.
- State ARMED: trigger frame is the first frame with s_axis_tvalid=1 that satisfies the mode.
  - Mode 0: any valid frame.
  - Mode 1: a valid frame in the same cycle as trig_in, or later if trig_in was seen earlier in ARMED (pending flag).
  - Mode 2: previous valid sample of the channel < level and current >= level (signed). The previous-sample register is invalidated at arm, so the first frame after arm can never trigger.
  - The trigger frame is written to the FIFO as frame 0; state moves to CAPTURE. If cfg_capture_len=1, state goes straight to DRAIN.
- State CAPTURE:
  - Each valid frame is written if FIFO count<FIFO_DEPTH, and frames_written increments.
  - After frame cfg_capture_len-1 is written, state moves to DRAIN.
- Overflow (valid frame while count==FIFO_DEPTH):
  - Full is registered; a same-cycle pop does not free a slot.
  - The frame is dropped, overflow is set, the capture ends, and state moves to DRAIN.
  - No further writes occur.
- State DRAIN: no writes. The FIFO continues to pop.
- FIFO:
  - First-word-fall-through. m_axis_tvalid = count!=0.
  - Pop on tvalid&tready; write and pop may occur in the same cycle.
  - m_axis_tdata stays stable while tvalid&!tready.
  - Write-to-tvalid latency is 1 cycle.
- m_axis_tlast = (state==DRAIN) && count==1.
  - DRAIN is entered only with count>=1, so every burst ends with exactly one tlast.
- Leaving DRAIN: the tlast beat handshake moves the state to IDLE and pulses done the same cycle.
- abort:
  - In ARMED it returns to IDLE with no output and no done.
  - In CAPTURE it goes to DRAIN, or to IDLE if count==0.
  - In IDLE or DRAIN it is ignored.
  - abort and arm in the same cycle: abort wins.
- frames_written saturates at 2^LEN_WIDTH-1 and holds its value after the burst until the next arm.

Decomposition:
- Package jesd_capture_pkg holds:
  - trigger mode constants TRIG_IMMEDIATE / TRIG_EXTERNAL / TRIG_LEVEL;
  - state encoding IDLE / ARMED / CAPTURE / DRAIN;
  - the channel slice-offset function.
- One sub-module: jesd_capture_fifo, a synchronous FWFT FIFO with count, full and empty outputs. Reusable by other single-clock stages.

Test Plan:
- Mode 0, len=4, frames carry a counter 0..9 with continuous valid from cycle 5, tready=1, arm at cycle 3 → 4 beats, tdata counter values 5..8, tlast on the 4th, done pulse, overflow=0.
- Mode 2, chan=3, level=100, channel 3 ramps 90, 95, 100, 105 → trigger on the frame with 100, which is frame 0. A sample of 100 first after arm → no trigger.
- Mode 1, trig_in pulse while tvalid=0 → capture starts on the next valid frame (pending flag honoured).
- len=32, FIFO_DEPTH=16, tready=0 → 16 frames written, the 17th dropped, overflow=1, frames_written=16. Then tready=1 → 16 beats, tlast on the 16th.
- Random tready (50%), len=100 → 100 beats in order, data stable under stall, exactly one tlast.
- Reset asserted mid-CAPTURE → next cycle tvalid=0, busy=0, and no stale data after re-arm.
- abort asserted during ARMED → returns to IDLE with no output beats and no done.
